// File: rtl/ps2_ascii_kbd.sv
// PS/2 scan-code set 2 keyboard front end: frame receiver, make/break decoder,
// Shift/Caps tracking and a level-held ASCII output for the character terminal.
module ps2_ascii_kbd #(
  parameter int CLK_HZ         = 50000000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii_out,
  output logic       key_down,
  output logic       new_key,
  output logic       frame_err,
  output logic       caps_on
);

  // A zero timeout falls back to 2 ms derived from the clock frequency.
  localparam int LIMIT  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : (CLK_HZ / 500);
  localparam int IDLE_W = $clog2(LIMIT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;

  logic [2:0]        clk_sync, data_sync;
  logic              fall, bit_in;
  logic [3:0]        bit_cnt;
  logic [8:0]        shift_reg;
  logic              start_bad;
  logic [IDLE_W-1:0] idle_cnt;
  logic              byte_valid;
  logic [7:0]        rx_byte;

  state_t     state, state_nxt;
  logic [7:0] ascii_nxt, hold_code, hold_code_nxt;
  logic       new_nxt, caps_nxt, caps_held, caps_held_nxt;
  logic       shift_l, shift_l_nxt, shift_r, shift_r_nxt, hold_ext, hold_ext_nxt;
  logic       is_make, is_break, ext;
  logic [8:0] map;

  // Returns {mapped, ascii} for a make of the given key.
  function automatic logic [8:0] key_map(input logic x, input logic [7:0] code,
                                         input logic upper, input logic shift);
    logic [7:0] ch;
    logic       ok, letter;
    ch = 8'h00; ok = 1'b1; letter = 1'b1;
    if (x) begin
      letter = 1'b0;
      case (code)
        8'h75:   ch = 8'h38;
        8'h72:   ch = 8'h32;
        8'h6B:   ch = 8'h34;
        8'h74:   ch = 8'h36;
        default: ok = 1'b0;
      endcase
    end else begin
      case (code)
        8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
        8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
        8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
        8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
        8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
        8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
        8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
        default: begin
          letter = 1'b0;
          case (code)
            8'h16:   ch = shift ? 8'h21 : 8'h31;
            8'h1E:   ch = shift ? 8'h40 : 8'h32;
            8'h26:   ch = shift ? 8'h23 : 8'h33;
            8'h25:   ch = shift ? 8'h24 : 8'h34;
            8'h2E:   ch = shift ? 8'h25 : 8'h35;
            8'h36:   ch = shift ? 8'h5E : 8'h36;
            8'h3D:   ch = shift ? 8'h26 : 8'h37;
            8'h3E:   ch = shift ? 8'h2A : 8'h38;
            8'h46:   ch = shift ? 8'h28 : 8'h39;
            8'h45:   ch = shift ? 8'h29 : 8'h30;
            8'h29:   ch = 8'h20;
            8'h5A:   ch = 8'h0D;
            8'h66:   ch = 8'h08;
            default: ok = 1'b0;
          endcase
        end
      endcase
    end
    if (letter && upper) ch = ch - 8'h20;
    return {ok, ch};
  endfunction

  assign fall     = clk_sync[2] & ~clk_sync[1];
  assign bit_in   = data_sync[1];
  assign key_down = (ascii_out != 8'h00);

  // Synchronizers idle high so reset never fabricates an edge on an idle bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
    end
  end

  // Frame receiver with idle timeout; shift_reg collects data then parity.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= 4'd0;
      shift_reg  <= 9'd0;
      start_bad  <= 1'b0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_byte    <= 8'h00;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (!start_bad && (^shift_reg) && bit_in) begin
            byte_valid <= 1'b1;
            rx_byte    <= shift_reg[7:0];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          if (bit_cnt == 4'd0) start_bad <= bit_in;
          else                 shift_reg <= {bit_in, shift_reg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        if (idle_cnt != IDLE_W'(LIMIT)) idle_cnt <= idle_cnt + {{(IDLE_W-1){1'b0}}, 1'b1};
        else if (bit_cnt != 4'd0)       bit_cnt  <= 4'd0;
      end
    end
  end

  // Decoder next state: prefix tracking, modifiers, mapping and hold register.
  always_comb begin
    state_nxt     = state;
    ascii_nxt     = ascii_out;
    new_nxt       = 1'b0;
    caps_nxt      = caps_on;
    caps_held_nxt = caps_held;
    shift_l_nxt   = shift_l;
    shift_r_nxt   = shift_r;
    hold_code_nxt = hold_code;
    hold_ext_nxt  = hold_ext;
    is_make       = 1'b0;
    is_break      = 1'b0;
    ext           = 1'b0;
    if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte == 8'hF0)      state_nxt = ST_BRK;
          else if (rx_byte == 8'hE0) state_nxt = ST_EXT;
          else                       is_make   = 1'b1;
        end
        ST_EXT: begin
          ext = 1'b1;
          if (rx_byte == 8'hF0) state_nxt = ST_EXT_BRK;
          else                  is_make   = 1'b1;
        end
        ST_BRK:     is_break = 1'b1;
        ST_EXT_BRK: begin is_break = 1'b1; ext = 1'b1; end
        default:    state_nxt = ST_IDLE;
      endcase
      if (is_make || is_break) state_nxt = ST_IDLE;
    end
    map = key_map(ext, rx_byte, (shift_l | shift_r) ^ caps_on, shift_l | shift_r);
    if (is_make) begin
      if (!ext && rx_byte == 8'h12)      shift_l_nxt = 1'b1;
      else if (!ext && rx_byte == 8'h59) shift_r_nxt = 1'b1;
      else if (!ext && rx_byte == 8'h58) begin
        if (!caps_held) caps_nxt = ~caps_on;
        caps_held_nxt = 1'b1;
        ascii_nxt     = 8'h14;
        hold_code_nxt = rx_byte;
        hold_ext_nxt  = 1'b0;
        new_nxt       = 1'b1;
      end else if (map[8]) begin
        ascii_nxt     = map[7:0];
        hold_code_nxt = rx_byte;
        hold_ext_nxt  = ext;
        new_nxt       = 1'b1;
      end else begin
        ascii_nxt = ascii_out;
      end
    end else if (is_break) begin
      if (!ext && rx_byte == 8'h12)      shift_l_nxt   = 1'b0;
      else if (!ext && rx_byte == 8'h59) shift_r_nxt   = 1'b0;
      else if (!ext && rx_byte == 8'h58) caps_held_nxt = 1'b0;
      else                               caps_held_nxt = caps_held;
      if (rx_byte == hold_code && ext == hold_ext) ascii_nxt = 8'h00;
    end else begin
      ascii_nxt = ascii_out;
    end
  end

  // Decoder state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ascii_out <= 8'h00;
      new_key   <= 1'b0;
      caps_on   <= 1'b0;
      caps_held <= 1'b0;
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      hold_code <= 8'h00;
      hold_ext  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ascii_out <= ascii_nxt;
      new_key   <= new_nxt;
      caps_on   <= caps_nxt;
      caps_held <= caps_held_nxt;
      shift_l   <= shift_l_nxt;
      shift_r   <= shift_r_nxt;
      hold_code <= hold_code_nxt;
      hold_ext  <= hold_ext_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_ascii_kbd.sv
// Randomized PS/2 stimulus checked every cycle against a table-driven keyboard
// model, plus hand-computed expectations along the directed scenarios.
module tb_ps2_ascii_kbd;
  localparam int TO = 400;

  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] ascii_out;
  logic key_down, new_key, frame_err, caps_on;

  ps2_ascii_kbd #(.CLK_HZ(50000000), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ascii_out(ascii_out), .key_down(key_down), .new_key(new_key),
    .frame_err(frame_err), .caps_on(caps_on));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, new_pulses = 0, err_pulses = 0;
  logic checking = 1'b0;

  // Model state: what the keyboard and terminal should see.
  logic [7:0] m_ascii;
  logic [8:0] m_hold;
  logic m_caps, m_caps_held, m_shl, m_shr, m_pend_brk, m_pend_ext, exp_new, exp_err;

  logic [7:0] letter_code [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
    8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,
    8'h22,8'h35,8'h1A};
  logic [7:0] digit_code [10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
  logic [7:0] arrow_code [4]  = '{8'h75,8'h72,8'h6B,8'h74};
  logic [7:0] arrow_char [4]  = '{8'h38,8'h32,8'h34,8'h36};
  string letters = "abcdefghijklmnopqrstuvwxyz";
  string digits  = "1234567890";
  string symbols = "!@#$%^&*()";

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void lookup(input logic x, input logic [7:0] code,
                                 output logic ok, output logic [7:0] ch);
    logic sh;
    sh = m_shl | m_shr;
    ok = 1'b0; ch = 8'h00;
    if (x) begin
      for (int i = 0; i < 4; i++)
        if (arrow_code[i] == code) begin ok = 1'b1; ch = arrow_char[i]; end
    end else begin
      for (int i = 0; i < 26; i++)
        if (letter_code[i] == code) begin
          ok = 1'b1; ch = letters[i];
          if (sh ^ m_caps) ch = ch - 8'd32;
        end
      for (int i = 0; i < 10; i++)
        if (digit_code[i] == code) begin ok = 1'b1; ch = sh ? symbols[i] : digits[i]; end
      if (code == 8'h29) begin ok = 1'b1; ch = 8'h20; end
      if (code == 8'h5A) begin ok = 1'b1; ch = 8'h0D; end
      if (code == 8'h66) begin ok = 1'b1; ch = 8'h08; end
    end
  endfunction

  task automatic model_reset();
    m_ascii = 8'h00; m_hold = 9'h000; m_caps = 1'b0; m_caps_held = 1'b0;
    m_shl = 1'b0; m_shr = 1'b0; m_pend_brk = 1'b0; m_pend_ext = 1'b0;
    exp_new = 1'b0; exp_err = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic ok, x, brk;
    logic [7:0] ch;
    if (b == 8'hF0 && !m_pend_brk) m_pend_brk = 1'b1;
    else if (b == 8'hE0 && !m_pend_brk && !m_pend_ext) m_pend_ext = 1'b1;
    else begin
      x = m_pend_ext; brk = m_pend_brk;
      m_pend_ext = 1'b0; m_pend_brk = 1'b0;
      if (!brk) begin
        lookup(x, b, ok, ch);
        if (!x && b == 8'h12) m_shl = 1'b1;
        else if (!x && b == 8'h59) m_shr = 1'b1;
        else if (!x && b == 8'h58) begin
          if (!m_caps_held) m_caps = !m_caps;
          m_caps_held = 1'b1; m_ascii = 8'h14; m_hold = {1'b0, b}; exp_new = 1'b1;
        end else if (ok) begin
          m_ascii = ch; m_hold = {x, b}; exp_new = 1'b1;
        end
      end else begin
        if (!x && b == 8'h12) m_shl = 1'b0;
        if (!x && b == 8'h59) m_shr = 1'b0;
        if (!x && b == 8'h58) m_caps_held = 1'b0;
        if ({x, b} == m_hold) m_ascii = 8'h00;
      end
    end
  endtask

  // Drives nbits of a frame; on a full frame the model follows the DUT pipeline.
  task automatic send_raw(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                          input int nbits);
    logic [10:0] bits;
    logic good;
    good = !bad_par && !bad_stop;
    bits = {!bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); ps2_data = bits[i];
      repeat (2) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (3) @(posedge clk);
        exp_err = !good;
        @(posedge clk);
        exp_err = 1'b0;
        if (good) model_byte(b);
        @(posedge clk);
        exp_new = 1'b0;
        @(negedge clk);
      end else begin
        repeat (6) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (6) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_raw(b, 1'b0, 1'b0, 11);
  endtask

  task automatic key(input logic x, input logic brk, input logic [7:0] code);
    if (x) send(8'hE0);
    if (brk) send(8'hF0);
    send(code);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      check("ascii_out", ascii_out, m_ascii);
      check("key_down", {7'd0, key_down}, {7'd0, m_ascii != 8'h00});
      check("new_key", {7'd0, new_key}, {7'd0, exp_new});
      check("frame_err", {7'd0, frame_err}, {7'd0, exp_err});
      check("caps_on", {7'd0, caps_on}, {7'd0, m_caps});
      if (new_key === 1'b1) new_pulses++;
      if (frame_err === 1'b1) err_pulses++;
    end
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int np, ne, r, idx;
    logic x, brk;
    logic [7:0] code;
    logic [7:0] pool_code [18] = '{8'h1C,8'h32,8'h21,8'h4D,8'h1A,8'h16,8'h1E,8'h45,8'h29,
      8'h5A,8'h66,8'h12,8'h59,8'h58,8'h75,8'h72,8'h6B,8'h74};
    model_reset();
    repeat (3) @(posedge clk);
    model_reset();
    checking = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("reset_ascii", ascii_out, 8'h00);
    check("reset_caps", {7'd0, caps_on}, 8'h00);

    np = new_pulses;
    key(0, 0, 8'h1C); check("make_a", ascii_out, 8'h61);
    check("make_a_pulse", 8'(new_pulses - np), 8'd1);
    check("make_a_kd", {7'd0, key_down}, 8'h01);
    key(0, 1, 8'h1C); check("break_a", ascii_out, 8'h00);
    key(0, 0, 8'h12); key(0, 0, 8'h1C); check("shift_a", ascii_out, 8'h41);
    key(0, 1, 8'h12); key(0, 1, 8'h1C);
    key(0, 0, 8'h58); check("caps_code", ascii_out, 8'h14);
    key(0, 1, 8'h58); key(0, 0, 8'h1C); check("caps_a", ascii_out, 8'h41);
    check("caps_on", {7'd0, caps_on}, 8'h01);
    key(0, 1, 8'h1C);
    key(0, 0, 8'h12); key(0, 0, 8'h1C); check("caps_shift_a", ascii_out, 8'h61);
    key(0, 1, 8'h1C); key(0, 1, 8'h12);
    key(0, 0, 8'h58); key(0, 0, 8'h58); key(0, 1, 8'h58);
    check("caps_typematic", {7'd0, caps_on}, 8'h00);
    key(0, 0, 8'h16); check("digit_1", ascii_out, 8'h31);
    key(0, 0, 8'h59); key(0, 0, 8'h1E); check("shift_2", ascii_out, 8'h40);
    key(0, 1, 8'h59); check("shift_rel_hold", ascii_out, 8'h40);
    key(0, 1, 8'h1E); key(0, 1, 8'h16);

    key(1, 0, 8'h75); check("up", ascii_out, 8'h38);
    np = new_pulses;
    repeat (5) key(1, 0, 8'h75);
    check("repeat_pulses", 8'(new_pulses - np), 8'd5);
    check("repeat_hold", ascii_out, 8'h38);
    key(1, 1, 8'h75); check("up_break", ascii_out, 8'h00);

    key(0, 0, 8'h1C); key(0, 0, 8'h32); key(0, 1, 8'h1C);
    check("rollover", ascii_out, 8'h62);
    key(0, 1, 8'h32); check("rollover_rel", ascii_out, 8'h00);

    ne = err_pulses;
    send_raw(8'h1C, 1'b1, 1'b0, 11); check("bad_parity", ascii_out, 8'h00);
    check("bad_parity_err", 8'(err_pulses - ne), 8'd1);
    ne = err_pulses;
    send_raw(8'h1C, 1'b0, 1'b1, 11);
    check("bad_stop_err", 8'(err_pulses - ne), 8'd1);
    key(0, 0, 8'h32); send(8'hF0); send_raw(8'h44, 1'b1, 1'b0, 11); send(8'h32);
    check("prefix_kept", ascii_out, 8'h00);

    ne = err_pulses;
    send_raw(8'h5A, 1'b0, 1'b0, 5);
    repeat (TO + 100) @(negedge clk);
    send(8'h5A); check("timeout_enter", ascii_out, 8'h0D);
    check("timeout_no_err", 8'(err_pulses - ne), 8'd0);
    key(0, 1, 8'h5A);

    key(0, 0, 8'h1C);
    send_raw(8'h32, 1'b0, 1'b0, 4);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); model_reset();
    @(negedge clk); reset = 1'b0;
    check("midreset_ascii", ascii_out, 8'h00);
    check("midreset_new", {7'd0, new_key}, 8'h00);
    key(0, 1, 8'h1C); check("stale_break", ascii_out, 8'h00);

    for (int n = 0; n < 100; n++) begin
      r = $urandom_range(0, 19);
      idx = $urandom_range(0, 18);
      if (idx == 18) begin
        code = 8'($urandom_range(0, 255)); x = 1'($urandom_range(0, 1));
      end else begin
        code = pool_code[idx]; x = (idx >= 14);
      end
      brk = ($urandom_range(0, 9) < 4);
      if (r == 0) send_raw(code, 1'b1, 1'b0, 11);
      else if (r == 1) send_raw(code, 1'b0, 1'b1, 11);
      else key(x, brk, code);
    end

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
